// File: rtl/neopixel_pixel_buffer.sv
// neopixel_pixel_buffer
//
// Frame buffer and pixel streamer that feeds the NeoPixel bit serializer. The host writes
// 24-bit pixel words into a small RAM. On START the block streams them in address order,
// starting at index 0. Each word is scaled per byte lane by a brightness factor, which is
// latched when the frame starts. Words are handed over on a valid/ready handshake, and the
// last pixel is flagged so the serializer can enter its latch period.
//
// Ports:
//   CLK_10MHZ    in   sole clock, rising edge
//   RESET        in   asynchronous active-high reset (aborts a frame in progress)
//   WR_EN        in   pixel RAM write strobe, honoured in every state
//   WR_ADDR      in   pixel index to write; indices >= PIXELS are dropped
//   WR_DATA      in   pixel word in serializer wire format
//   BRIGHTNESS   in   global scale factor, latched at frame start
//   START        in   frame request, only looked at while idle
//   PIXEL_READY  in   serializer accepts the presented pixel
//   PIXEL_VALID  out  PIXEL_DATA holds a pixel
//   PIXEL_DATA   out  scaled pixel word
//   PIXEL_LAST   out  presented pixel is index PIXELS-1 (qualified by PIXEL_VALID)
//   BUSY         out  frame in progress
//   FRAME_DONE   out  one-cycle pulse after the last handshake

module neopixel_pixel_buffer #(
    parameter int unsigned PIXELS     = 2,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  CLK_10MHZ,
    input  logic                  RESET,
    input  logic                  WR_EN,
    input  logic [ADDR_WIDTH-1:0] WR_ADDR,
    input  logic [23:0]           WR_DATA,
    input  logic [7:0]            BRIGHTNESS,
    input  logic                  START,
    input  logic                  PIXEL_READY,
    output logic                  PIXEL_VALID,
    output logic [23:0]           PIXEL_DATA,
    output logic                  PIXEL_LAST,
    output logic                  BUSY,
    output logic                  FRAME_DONE
);

    // RAM index width; the RAM holds exactly PIXELS words.
    localparam int unsigned IdxW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    // One extra bit so PIXELS == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0]   NumPixels = (ADDR_WIDTH + 1)'(PIXELS);
    localparam logic [ADDR_WIDTH-1:0] LastIdx   = ADDR_WIDTH'(PIXELS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StLoad,
        StPresent
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   rd_idx_q, rd_idx_d;
    logic [7:0]              bright_q, bright_d;
    logic                    valid_q, valid_d;
    logic [23:0]             data_q, data_d;
    logic                    last_q, last_d;
    logic                    done_q, done_d;
    logic [23:0]             ram_q;
    logic                    rd_en;
    logic                    wr_ok;
    logic                    handshake;

    logic [23:0] mem [PIXELS];

    // Per-lane (c * (b + 1)) >> 8: b = 255 is an exact pass-through, b = 0 gives zero.
    function automatic logic [23:0] scale(input logic [23:0] px, input logic [7:0] b);
        logic [15:0] factor;
        logic [15:0] prod;
        logic [23:0] res;
        factor = 16'(b) + 16'd1;
        res    = '0;
        for (int l = 0; l < 3; l++) begin
            prod            = 16'(px[8*l +: 8]) * factor;
            res[8*l +: 8]   = prod[15:8];
        end
        return res;
    endfunction

    assign wr_ok     = WR_EN && ({1'b0, WR_ADDR} < NumPixels);
    assign handshake = valid_q && PIXEL_READY;

    // Pixel RAM: not reset. The non-blocking read and write on the same edge give
    // read-before-write when both hit the same address.
    always_ff @(posedge CLK_10MHZ) begin
        if (wr_ok) begin
            mem[WR_ADDR[IdxW-1:0]] <= WR_DATA;
        end
        if (rd_en) begin
            ram_q <= mem[rd_idx_q[IdxW-1:0]];
        end
    end

    // State register
    always_ff @(posedge CLK_10MHZ or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (START) state_d = StFetch;
            StFetch:   state_d = StLoad;
            StLoad:    state_d = StPresent;
            StPresent: if (handshake) state_d = last_q ? StIdle : StFetch;
            default:   state_d = StIdle;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        rd_idx_d = rd_idx_q;
        bright_d = bright_q;
        valid_d  = valid_q;
        data_d   = data_q;
        last_d   = last_q;
        done_d   = 1'b0;
        rd_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    bright_d = BRIGHTNESS;
                    rd_idx_d = '0;
                end
            end
            StFetch: begin
                rd_en = 1'b1;
            end
            StLoad: begin
                data_d  = scale(ram_q, bright_q);
                valid_d = 1'b1;
                last_d  = (rd_idx_q == LastIdx);
            end
            StPresent: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        done_d = 1'b1;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_10MHZ or posedge RESET) begin
        if (RESET) begin
            rd_idx_q <= '0;
            bright_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            rd_idx_q <= rd_idx_d;
            bright_q <= bright_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            last_q   <= last_d;
            done_q   <= done_d;
        end
    end

    assign PIXEL_VALID = valid_q;
    assign PIXEL_DATA  = data_q;
    assign PIXEL_LAST  = last_q;
    assign FRAME_DONE  = done_q;
    assign BUSY        = (state_q != StIdle);

endmodule

// File: tb/tb_neopixel_pixel_buffer.sv
// Testbench for neopixel_pixel_buffer: directed plus randomized frames checked against a
// behavioural model (pixel array + arithmetic brightness scaling).

module tb_neopixel_pixel_buffer;

    localparam int unsigned PIXELS = 2;
    localparam int unsigned AW     = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic [7:0]    brightness;
    logic          start;
    logic          ready;
    logic          pixel_valid;
    logic [23:0]   pixel_data;
    logic          pixel_last;
    logic          busy;
    logic          frame_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [23:0] mem_m[$];

    always #5 clk = ~clk;

    neopixel_pixel_buffer #(
        .PIXELS     (PIXELS),
        .ADDR_WIDTH (AW)
    ) dut (
        .CLK_10MHZ   (clk),
        .RESET       (rst),
        .WR_EN       (wr_en),
        .WR_ADDR     (wr_addr),
        .WR_DATA     (wr_data),
        .BRIGHTNESS  (brightness),
        .START       (start),
        .PIXEL_READY (ready),
        .PIXEL_VALID (pixel_valid),
        .PIXEL_DATA  (pixel_data),
        .PIXEL_LAST  (pixel_last),
        .BUSY        (busy),
        .FRAME_DONE  (frame_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each lane scaled by (b+1)/256, truncated.
    function automatic logic [23:0] ref_scale(input logic [23:0] px, input int b);
        int r;
        r = 0;
        for (int l = 0; l < 3; l++) begin
            r += (((int'(px) >> (8 * l)) & 255) * (b + 1) / 256) << (8 * l);
        end
        return 24'(r);
    endfunction

    task automatic wr(input int addr, input logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (addr < int'(PIXELS)) mem_m[addr] = d;
    endtask

    // One full frame. stall < 0: random backpressure 0..3 cycles per pixel.
    // hazard 1: write pixel 1 on pixel 0's handshake edge (new value must stream).
    // hazard 2: write pixel 0 on its fetch edge (old value must stream).
    task automatic run_frame(input int bright, input int stall, input int hazard);
        int          latched;
        int          waited;
        int          nst;
        logic [23:0] exp_d;
        logic [23:0] hz_data;
        logic        exp_l;
        latched    = bright;
        hz_data    = '0;
        brightness = 8'(bright);
        start      = 1'b1;
        ready      = 1'b0;
        tick();
        start      = 1'b0;
        brightness = 8'($urandom);
        check_eq("busy_after_start", 32'(busy), 1);
        check_eq("valid_after_start", 32'(pixel_valid), 0);
        if (hazard == 2) begin
            hz_data = 24'($urandom);
            wr_en   = 1'b1;
            wr_addr = '0;
            wr_data = hz_data;
        end
        for (int idx = 0; idx < int'(PIXELS); idx++) begin
            waited = 0;
            while (!pixel_valid && waited < 8) begin
                ready = 1'($urandom);
                start = 1'($urandom);
                tick();
                waited++;
                wr_en = 1'b0;
                check_eq("busy_in_frame", 32'(busy), 1);
                check_eq("done_in_frame", 32'(frame_done), 0);
            end
            start = 1'b0;
            ready = 1'b0;
            check_eq("valid_latency", 32'(waited), 2);
            if (!pixel_valid) return;
            exp_d = ref_scale(mem_m[idx], latched);
            exp_l = (idx == int'(PIXELS) - 1);
            if (hazard == 2 && idx == 0) mem_m[0] = hz_data;
            check_eq("pixel_data", 32'(pixel_data), 32'(exp_d));
            check_eq("pixel_last", 32'(pixel_last), 32'(exp_l));
            nst = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            for (int k = 0; k < nst; k++) begin
                ready      = 1'b0;
                start      = 1'($urandom);
                brightness = 8'($urandom);
                tick();
                check_eq("hold_valid", 32'(pixel_valid), 1);
                check_eq("hold_data", 32'(pixel_data), 32'(exp_d));
                check_eq("hold_last", 32'(pixel_last), 32'(exp_l));
                check_eq("hold_busy", 32'(busy), 1);
            end
            start = 1'b0;
            ready = 1'b1;
            if (hazard == 1 && idx == 0 && PIXELS > 1) begin
                hz_data   = 24'($urandom);
                wr_en     = 1'b1;
                wr_addr   = AW'(1);
                wr_data   = hz_data;
                mem_m[1]  = hz_data;
            end
            tick();
            ready = 1'b0;
            wr_en = 1'b0;
            check_eq("valid_after_hs", 32'(pixel_valid), 0);
            if (exp_l) begin
                check_eq("done_pulse", 32'(frame_done), 1);
                check_eq("busy_after_last", 32'(busy), 0);
            end else begin
                check_eq("done_early", 32'(frame_done), 0);
                check_eq("busy_mid", 32'(busy), 1);
            end
        end
        tick();
        check_eq("done_one_cycle", 32'(frame_done), 0);
        check_eq("no_second_frame", 32'(busy), 0);
        tick();
        check_eq("idle_valid", 32'(pixel_valid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(PIXELS); i++) mem_m.push_back('0);
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        brightness = '0;
        start      = 1'b0;
        ready      = 1'b0;
        tick();
        tick();
        check_eq("rst_valid", 32'(pixel_valid), 0);
        check_eq("rst_data", 32'(pixel_data), 0);
        check_eq("rst_last", 32'(pixel_last), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(frame_done), 0);
        rst = 1'b0;
        tick();

        // Basic frame, pass-through brightness, no backpressure
        wr(0, 24'hff00d5);
        wr(1, 24'h123456);
        run_frame(255, 0, 0);

        // Scaling
        wr(0, 24'hff8001);
        run_frame(127, 0, 0);
        run_frame(0, -1, 0);

        // Long backpressure
        run_frame(int'($urandom_range(0, 255)), 20, 0);

        // Out-of-range write is dropped
        wr(2, 24'habcdef);
        run_frame(255, -1, 0);

        // Write hazards
        run_frame(200, -1, 1);
        run_frame(255, -1, 2);

        // Reset while a pixel is presented
        brightness = 8'd255;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_eq("rst_pre_valid", 32'(pixel_valid), 1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_valid", 32'(pixel_valid), 0);
        check_eq("arst_data", 32'(pixel_data), 0);
        check_eq("arst_last", 32'(pixel_last), 0);
        check_eq("arst_busy", 32'(busy), 0);
        check_eq("arst_done", 32'(frame_done), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check_eq("post_rst_done", 32'(frame_done), 0);
        check_eq("post_rst_busy", 32'(busy), 0);
        run_frame(255, -1, 0);

        // Randomized frames
        for (int f = 0; f < 25; f++) begin
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
                wr(int'($urandom_range(0, 3)), 24'($urandom));
            end
            run_frame(int'($urandom_range(0, 255)), -1, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/neopixel_pixel_buffer.md
# neopixel_pixel_buffer

Frame buffer and pixel streamer directly upstream of the NeoPixel bit serializer. Holds `PIXELS` 24-bit pixel words written by the host side, and on a frame start streams them in address order, index 0 first. Each word is scaled by a global brightness factor before it is handed to the serializer over a valid/ready handshake. It signals the last pixel of the frame so the serializer can enter its latch/reset period.

## Interface
- `PIXELS`, default 2: number of pixels in the strip (≥1).
- `ADDR_WIDTH`, default 8: pixel address width; 2^`ADDR_WIDTH` ≥ `PIXELS` is required.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `CLK_10MHZ` in, 1: sole clock; all logic on the rising edge.
- `RESET` in, 1: asynchronous, active-high reset.
- `WR_EN` in, 1: write strobe for the pixel RAM.
- `WR_ADDR` in, `ADDR_WIDTH`: pixel index to write.
- `WR_DATA` in, 24: pixel word, stored bit-for-bit in serializer wire format.
- `BRIGHTNESS` in, 8: global scale factor, latched at frame start.
- `START` in, 1: frame request; sampled only in IDLE.
- `PIXEL_READY` in, 1: serializer accepts the presented pixel.
- `PIXEL_VALID` out, 1: `PIXEL_DATA` holds a pixel.
- `PIXEL_DATA` out, 24: scaled pixel word.
- `PIXEL_LAST` out, 1: presented pixel is index `PIXELS`-1; qualified by `PIXEL_VALID`.
- `BUSY` out, 1: a frame is in progress (state ≠ IDLE).
- `FRAME_DONE` out, 1: one-cycle pulse after the last handshake.

## Operation
- **Pixel RAM**
  - `PIXELS`×24 storage, with a synchronous write port and a registered synchronous read port.
  - A write with `WR_ADDR` ≥ `PIXELS` is ignored.
  - Writes are accepted in every state.
  - A write to an address not yet fetched in the current frame is visible in that frame.
  - A write and a read to the same address on the same edge returns the old data (read-before-write).
  - Contents are not cleared by `RESET`; they are undefined until written.
- **FSM states:** IDLE, FETCH, LOAD, PRESENT.
  - IDLE: if `START`=1, latch `BRIGHTNESS` into `bright_q`, set `rd_idx`=0, go to FETCH.
  - FETCH: RAM read of `rd_idx` into `ram_q`, go to LOAD.
  - LOAD: `PIXEL_DATA` ← scale(`ram_q`), `PIXEL_VALID` ← 1, `PIXEL_LAST` ← (`rd_idx` == `PIXELS`-1), go to PRESENT.
  - PRESENT: hold all outputs until `PIXEL_VALID` & `PIXEL_READY`. On that handshake, clear `PIXEL_VALID` and `PIXEL_LAST`, then:
    - if not last, `rd_idx`+1 and go to FETCH;
    - if last, pulse `FRAME_DONE` and go to IDLE.
- **Scaling**, per byte lane [23:16], [15:8], [7:0]: out = (c × (`bright_q`+1)) >> 8.
  - The product is 16 bits unsigned; the upper byte is taken with no rounding.
  - `bright_q`=255 passes data through exactly; `bright_q`=0 yields 0.
- `START` in any state other than IDLE is ignored; it is not queued.
- `BRIGHTNESS` changes mid-frame have no effect until the next frame start.
- `PIXEL_READY` while `PIXEL_VALID`=0 is ignored.
- `PIXELS`=1: the single pixel is presented with `PIXEL_LAST`=1.

## Timing
- Reset values: `PIXEL_VALID`=0, `PIXEL_DATA`=0, `PIXEL_LAST`=0, `BUSY`=0, `FRAME_DONE`=0, state IDLE, `rd_idx`=0, `bright_q`=0.
- Reset mid-frame aborts the frame immediately (asynchronously). No `FRAME_DONE` is produced, and the next `START` restarts at pixel 0.
- `START` sampled on edge S: `BUSY`=1 after S; `PIXEL_VALID`=1 after edge S+2.
- Handshake on edge E (not last): `PIXEL_VALID`=0 after E; the next pixel is valid after E+2.
- Handshake on the last pixel at edge E: `FRAME_DONE`=1 and `BUSY`=0 for the cycle after E.
  - A `START` sampled on edge E+1 begins a new frame.
- `PIXEL_DATA` and `PIXEL_LAST` are stable for as long as `PIXEL_VALID`=1 and `PIXEL_READY`=0.
- Throughput is one pixel per 3 cycles maximum. This is far above the serializer demand of 288 cycles per pixel.

## Test plan
- **Reset:** assert `RESET` mid-PRESENT → all outputs 0 immediately. Then `START` → pixel 0 presented again, after edge S+2.
- **Basic frame** (`PIXELS`=2, `BRIGHTNESS`=255): write 0xff00d5 to address 0 and 0x123456 to address 1, pulse `START`, hold `PIXEL_READY`=1.
  - Required: 0xff00d5 with LAST=0, then 0x123456 with LAST=1.
  - Required: `FRAME_DONE` pulses exactly once; `BUSY` is high from S+1 to the final handshake.
- **Scaling:** `BRIGHTNESS`=127, pixel 0xff8001 → `PIXEL_DATA`=0x7f4000. `BRIGHTNESS`=0 → 0x000000.
- **Backpressure:** hold `PIXEL_READY`=0 for 20 cycles after `PIXEL_VALID` rises → `PIXEL_DATA` and `PIXEL_LAST` are unchanged throughout. Raising `PIXEL_READY` completes the handshake in 1 cycle.
- **Ignored inputs:**
  - `START` pulsed while `BUSY` → no second frame.
  - `BRIGHTNESS` changed mid-frame → pixel 1 uses the latched value.
  - Write to `WR_ADDR`=2 → RAM is unchanged.
- **Write hazards:**
  - Write to address 1 while pixel 0 is presented → the new value is streamed for pixel 1.
  - Write to address 0 on the FETCH edge of pixel 0 → the old value is streamed.
